// File: rtl/spi_target_regs.sv
// spi_target_regs: SPI mode-0 target that turns command/data frames into
// register-bus write strobes and read requests.
// The SPI pins are oversampled in the clk domain.
// Optional burst mode: define SPI_TGT_AUTOINC_EN. In burst mode the address
// auto-increments after each completed data word while cs stays low.
module spi_target_regs #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   input  logic              spi_cs,
   output logic              spi_miso,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              frame_err
);

   localparam int CNT_W = (DATA_W > 8) ? $clog2(DATA_W) : 3;
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, CMD, DATA, DONE, WAIT_CS} state_t;

   // bit 0 = spi_clk, bit 1 = spi_mosi, bit 2 = spi_cs
   logic [2:0] sync1_reg, sync2_reg;
   logic       sclk_prev_reg;

   state_t              state_reg;
   logic [CNT_W-1:0]    bit_cnt_reg;
   logic [DATA_W-2:0]   shift_reg;
   logic [DATA_W-1:0]   tx_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic                write_mode_reg;
   logic                first_word_reg;
   logic                cap_pend_reg;

   logic              sclk_s, mosi_s, cs_n_s;
   logic              rise, fall;
   logic [DATA_W-1:0] data_word;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_write;

   assign sclk_s = sync2_reg[0];
   assign mosi_s = sync2_reg[1];
   assign cs_n_s = sync2_reg[2];
   assign rise   = sclk_s & ~sclk_prev_reg;
   assign fall   = ~sclk_s & sclk_prev_reg;

   // The word including the bit arriving on this rise; its low byte is the command
   assign data_word = {shift_reg, mosi_s};
   assign cmd_addr  = data_word[ADDR_W-1:0];
   assign cmd_write = data_word[7];

   // Two-flop synchronisers on the SPI pins plus a delayed copy of spi_clk for edge detect
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_reg     <= '0;
         sync2_reg     <= '0;
         sclk_prev_reg <= 1'b0;
      end else begin
         sync1_reg     <= {spi_cs, spi_mosi, spi_clk};
         sync2_reg     <= sync1_reg;
         sclk_prev_reg <= sync2_reg[0];
      end
   end

   // Frame decoder: command/data shifting, strobes, abort detection and the read TX register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= WAIT_CS;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         tx_reg         <= '0;
         addr_reg       <= '0;
         write_mode_reg <= 1'b0;
         first_word_reg <= 1'b0;
         cap_pend_reg   <= 1'b0;
         wr_en          <= 1'b0;
         wr_addr        <= '0;
         wr_data        <= '0;
         rd_en          <= 1'b0;
         rd_addr        <= '0;
         busy           <= 1'b0;
         frame_err      <= 1'b0;
      end else begin
         wr_en        <= 1'b0;
         rd_en        <= 1'b0;
         frame_err    <= 1'b0;
         // rd_data is valid the cycle after rd_en, so load it one cycle later
         cap_pend_reg <= rd_en;

         // No shift on the fall that precedes the first data rise: the MSB must stay put
         if (cap_pend_reg)
            tx_reg <= rd_data;
         else if (fall && state_reg == DATA && !write_mode_reg && bit_cnt_reg != '0)
            tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};

         case (state_reg)
            WAIT_CS: begin
               if (cs_n_s)
                  state_reg <= IDLE;
            end
            IDLE: begin
               if (!cs_n_s) begin
                  state_reg      <= CMD;
                  bit_cnt_reg    <= '0;
                  busy           <= 1'b1;
                  first_word_reg <= 1'b1;
               end
            end
            CMD: begin
               if (cs_n_s) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                  frame_err <= 1'b1;
               end else if (rise) begin
                  shift_reg <= data_word[DATA_W-2:0];
                  if (bit_cnt_reg == CMD_LAST) begin
                     bit_cnt_reg    <= '0;
                     state_reg      <= DATA;
                     write_mode_reg <= cmd_write;
                     addr_reg       <= cmd_addr;
                     if (!cmd_write) begin
                        rd_en   <= 1'b1;
                        rd_addr <= cmd_addr;
                     end
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                  end
               end
            end
            DATA: begin
               if (cs_n_s) begin
                  // A partial trailing burst word is a normal end of frame
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                  frame_err <= first_word_reg;
               end else if (rise) begin
                  shift_reg <= data_word[DATA_W-2:0];
                  if (bit_cnt_reg == DATA_LAST) begin
                     bit_cnt_reg <= '0;
                     if (write_mode_reg) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_reg;
                        wr_data <= data_word;
                     end
`ifdef SPI_TGT_AUTOINC_EN
                     first_word_reg <= 1'b0;
                     addr_reg       <= addr_reg + ADDR_W'(1);
                     if (!write_mode_reg) begin
                        rd_en   <= 1'b1;
                        rd_addr <= addr_reg + ADDR_W'(1);
                     end
`else
                     state_reg <= DONE;
`endif
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (cs_n_s) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state_reg <= WAIT_CS;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // MISO drives the TX MSB only during the data phase of a read frame
   always_ff @(posedge clk) begin
      if (!rst)
         spi_miso <= 1'b0;
      else
         spi_miso <= (state_reg == DATA && !write_mode_reg && !cs_n_s) ? tx_reg[DATA_W-1] : 1'b0;
   end

endmodule

// File: tb/tb_spi_target_regs.sv
// tb_spi_target_regs: bench for spi_target_regs with a bit-banged SPI
// controller and a scoreboard of expected write/read transactions.
// Define SPI_TGT_AUTOINC_EN to also exercise burst mode.
`timescale 1ns/1ps
module tb_spi_target_regs;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;
   localparam int HALF   = 5;   // spi_clk = clk/10

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              spi_clk;
   logic              spi_mosi;
   logic              spi_cs;
   logic              spi_miso;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              frame_err;

   logic [DATA_W-1:0] mem [16];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int rise_cyc = 0;
   int rise40_cyc = 0;
   int wr_cyc = 0;
   int err_cnt = 0;
   logic miso_seen = 1'b0;

   wr_t               exp_wr_q[$];
   logic [ADDR_W-1:0] exp_rd_q[$];
   wr_t               mon_wr;
   logic [ADDR_W-1:0] mon_rd;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Register model answering read requests
   assign rd_data = mem[rd_addr];

   spi_target_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
      .spi_miso(spi_miso), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .frame_err(frame_err)
   );

   // Scoreboard: pop the expected transaction whenever the DUT issues a strobe
   always @(negedge clk) begin
      if (wr_en) begin
         n_cmp++;
         wr_cyc = cyc;
         if (exp_wr_q.size() == 0) begin
            n_bad++;
            $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", wr_addr, wr_data);
         end else begin
            mon_wr = exp_wr_q.pop_front();
            if (wr_addr !== mon_wr.addr || wr_data !== mon_wr.data) begin
               n_bad++;
               $display("FAIL wr_txn: got addr=%0d data=%h, required addr=%0d data=%h",
                        wr_addr, wr_data, mon_wr.addr, mon_wr.data);
            end else begin
               $display("write addr=%0d data=%h", wr_addr, wr_data);
            end
         end
      end
      if (rd_en) begin
         n_cmp++;
         if (exp_rd_q.size() == 0) begin
            n_bad++;
            $display("FAIL rd_unexpected: got addr=%0d, required no read", rd_addr);
         end else begin
            mon_rd = exp_rd_q.pop_front();
            if (rd_addr !== mon_rd) begin
               n_bad++;
               $display("FAIL rd_txn: got addr=%0d, required addr=%0d", rd_addr, mon_rd);
            end else begin
               $display("read  addr=%0d", rd_addr);
            end
         end
      end
      if (frame_err) err_cnt++;
      if (spi_miso) miso_seen = 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit, required completion");
      $fatal(1, "timeout");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b, output logic m);
      spi_mosi = b;
      wait_clk(HALF);
      spi_clk  = 1'b1;
      m        = spi_miso;
      rise_cyc = cyc;
      wait_clk(HALF);
      spi_clk  = 1'b0;
   endtask

   task automatic spi_frame(input logic [7:0] cmd, input logic [DATA_W-1:0] d0,
                            input logic [DATA_W-1:0] d1, input int nbits,
                            output logic [DATA_W-1:0] rx0, output logic [DATA_W-1:0] rx1);
      logic [71:0] stream;
      logic m;
      stream = {cmd, d0, d1};
      rx0 = '0;
      rx1 = '0;
      spi_cs = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < nbits; i++) begin
         spi_bit((i < 72) ? stream[71-i] : 1'b0, m);
         if (i >= 8 && i < 40) rx0 = {rx0[DATA_W-2:0], m};
         else if (i >= 40 && i < 72) rx1 = {rx1[DATA_W-2:0], m};
         if (i == 39) rise40_cyc = rise_cyc;
      end
      wait_clk(HALF);
      spi_cs = 1'b1;
      wait_clk(12);
   endtask

   task automatic test_reset();
      logic [7+DATA_W:0] stream;
      logic m;
      logic [DATA_W-1:0] r0, r1;
      int e0;
      rst = 1'b0; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
      wait_clk(4);
      n_cmp++;
      if ({spi_miso, wr_en, rd_en, frame_err, busy, wr_addr, wr_data, rd_addr} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got miso=%b wr=%b rd=%b err=%b busy=%b wa=%0d wd=%h ra=%0d, required all 0",
                  spi_miso, wr_en, rd_en, frame_err, busy, wr_addr, wr_data, rd_addr);
      end
      rst = 1'b1;
      wait_clk(6);
      // Frame interrupted by a 2-cycle reset must never decode
      e0 = err_cnt;
      stream = {8'h87, 32'h0BAD_0BAD};
      spi_cs = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < 12; i++) spi_bit(stream[39-i], m);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_midframe: got %b, required 1", busy);
      end
      rst = 1'b0;
      wait_clk(2);
      rst = 1'b1;
      for (int i = 12; i < 40; i++) spi_bit(stream[39-i], m);
      wait_clk(4);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_after_reset: got %b, required 0", busy);
      end
      wait_clk(HALF);
      spi_cs = 1'b1;
      wait_clk(12);
      n_cmp++;
      if (err_cnt - e0 != 0) begin
         n_bad++;
         $display("FAIL reset_frame_err: got %0d pulses, required 0", err_cnt - e0);
      end
      // Next frame decodes normally
      exp_wr_q.push_back('{addr: 4'd7, data: 32'hCAFE_F00D});
      spi_frame(8'h87, 32'hCAFE_F00D, '0, 40, r0, r1);
      n_cmp++;
      if (exp_wr_q.size() != 0) begin
         n_bad++;
         $display("FAIL reset_recover: got %0d writes missing, required 0", exp_wr_q.size());
         exp_wr_q.delete();
      end
   endtask

   task automatic test_write();
      logic [DATA_W-1:0] r0, r1;
      int e0;
      e0 = err_cnt;
      miso_seen = 1'b0;
      exp_wr_q.push_back('{addr: 4'd3, data: 32'hA5A5_A5A5});
      spi_frame(8'h83, 32'hA5A5_A5A5, '0, 40, r0, r1);
      n_cmp++;
      if (exp_wr_q.size() != 0) begin
         n_bad++;
         $display("FAIL write_missing: got %0d writes missing, required 0", exp_wr_q.size());
         exp_wr_q.delete();
      end
      n_cmp++;
      if (wr_cyc - rise40_cyc < 1 || wr_cyc - rise40_cyc > 4) begin
         n_bad++;
         $display("FAIL write_latency: got %0d clk after 40th rise, required 1..4", wr_cyc - rise40_cyc);
      end
      n_cmp++;
      if (miso_seen !== 1'b0) begin
         n_bad++;
         $display("FAIL write_miso: got miso high during write, required 0");
      end
      n_cmp++;
      if (err_cnt != e0) begin
         n_bad++;
         $display("FAIL write_err: got %0d frame_err, required 0", err_cnt - e0);
      end
   endtask

   task automatic test_read();
      logic [DATA_W-1:0] r0, r1;
      mem[5] = 32'h5A5A_5A5A;
      exp_rd_q.push_back(4'd5);
`ifdef SPI_TGT_AUTOINC_EN
      exp_rd_q.push_back(4'd6);
`endif
      spi_frame(8'h05, '0, '0, 40, r0, r1);
      n_cmp++;
      if (r0 !== 32'h5A5A_5A5A) begin
         n_bad++;
         $display("FAIL read_miso: got %h, required %h", r0, 32'h5A5A_5A5A);
      end
      n_cmp++;
      if (exp_rd_q.size() != 0) begin
         n_bad++;
         $display("FAIL read_missing: got %0d reads missing, required 0", exp_rd_q.size());
         exp_rd_q.delete();
      end
`ifndef SPI_TGT_AUTOINC_EN
      n_cmp++;
      if (rd_addr !== 4'd5) begin
         n_bad++;
         $display("FAIL read_addr_hold: got %0d, required 5", rd_addr);
      end
`endif
   endtask

   task automatic test_abort();
      logic [DATA_W-1:0] r0, r1;
      int e0;
      e0 = err_cnt;
      spi_frame(8'h82, 32'hFFFF_0000, '0, 20, r0, r1);
      n_cmp++;
      if (err_cnt - e0 != 1) begin
         n_bad++;
         $display("FAIL abort_err: got %0d pulses, required 1", err_cnt - e0);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_busy: got %b, required 0", busy);
      end
      exp_wr_q.push_back('{addr: 4'd1, data: 32'h1234_5678});
      spi_frame(8'h81, 32'h1234_5678, '0, 40, r0, r1);
      n_cmp++;
      if (exp_wr_q.size() != 0 || err_cnt - e0 != 1) begin
         n_bad++;
         $display("FAIL abort_recover: got %0d missing, %0d errs, required 0 missing, 1 err",
                  exp_wr_q.size(), err_cnt - e0);
         exp_wr_q.delete();
      end
   endtask

   task automatic test_extra_clocks();
      logic [DATA_W-1:0] r0, r1;
      int e0;
      e0 = err_cnt;
      exp_wr_q.push_back('{addr: 4'd10, data: 32'hDEAD_BEEF});
      spi_frame(8'h8A, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 48, r0, r1);
      n_cmp++;
      if (exp_wr_q.size() != 0 || err_cnt != e0) begin
         n_bad++;
         $display("FAIL extra_clocks: got %0d missing, %0d errs, required 0 and 0",
                  exp_wr_q.size(), err_cnt - e0);
         exp_wr_q.delete();
      end
   endtask

`ifdef SPI_TGT_AUTOINC_EN
   task automatic test_autoinc();
      logic [DATA_W-1:0] r0, r1;
      int e0;
      e0 = err_cnt;
      exp_wr_q.push_back('{addr: 4'd15, data: 32'h1111_1111});
      exp_wr_q.push_back('{addr: 4'd0,  data: 32'h2222_2222});
      spi_frame(8'h8F, 32'h1111_1111, 32'h2222_2222, 72, r0, r1);
      n_cmp++;
      if (exp_wr_q.size() != 0 || err_cnt != e0) begin
         n_bad++;
         $display("FAIL autoinc_write: got %0d missing, %0d errs, required 0 and 0",
                  exp_wr_q.size(), err_cnt - e0);
         exp_wr_q.delete();
      end
      mem[15] = 32'hC3C3_0F0F;
      mem[0]  = 32'h9669_1EE1;
      exp_rd_q.push_back(4'd15);
      exp_rd_q.push_back(4'd0);
      exp_rd_q.push_back(4'd1);
      spi_frame(8'h0F, '0, '0, 72, r0, r1);
      n_cmp++;
      if (r0 !== 32'hC3C3_0F0F || r1 !== 32'h9669_1EE1) begin
         n_bad++;
         $display("FAIL autoinc_read: got %h %h, required %h %h", r0, r1, 32'hC3C3_0F0F, 32'h9669_1EE1);
      end
      n_cmp++;
      if (exp_rd_q.size() != 0) begin
         n_bad++;
         $display("FAIL autoinc_rd_missing: got %0d missing, required 0", exp_rd_q.size());
         exp_rd_q.delete();
      end
   endtask
`endif

   task automatic test_back_to_back();
      logic [DATA_W-1:0] r0, r1, d;
      logic [ADDR_W-1:0] a;
      for (int k = 0; k < 6; k++) begin
         a = ADDR_W'($urandom_range(0, 15));
         d = $urandom;
         if (k % 2 == 0) begin
            exp_wr_q.push_back('{addr: a, data: d});
            spi_frame({4'h8, a}, d, '0, 40, r0, r1);
         end else begin
            mem[a] = d;
            exp_rd_q.push_back(a);
`ifdef SPI_TGT_AUTOINC_EN
            exp_rd_q.push_back(a + ADDR_W'(1));
`endif
            spi_frame({4'h0, a}, '0, '0, 40, r0, r1);
            n_cmp++;
            if (r0 !== d) begin
               n_bad++;
               $display("FAIL b2b_read: got %h, required %h", r0, d);
            end
         end
      end
      n_cmp++;
      if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
         n_bad++;
         $display("FAIL b2b_missing: got %0d writes, %0d reads missing, required 0",
                  exp_wr_q.size(), exp_rd_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_extra_clocks();
`ifdef SPI_TGT_AUTOINC_EN
      test_autoinc();
`endif
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
